// File: rtl/case4_operand_sequencer_if.sv
// Operand sequencer bundle: start/busy/done control, operand memory read port, indexed operand stream.
// master = sequencer side (drives busy/done/rd_en/rd_addr/out_*); slave = controller, memory and compute core.
// With CASE4_SEQ_ABORT_EN defined the bundle also carries a 1-bit abort request into the sequencer.
interface case4_operand_sequencer_if #(
    parameter int J      = 4,
    parameter int I      = 7,
    parameter int A      = 4,
    parameter int DATA_W = 16
);
    localparam int J_WIDTH = $clog2(J) + 1;
    localparam int I_WIDTH = $clog2(I) + 1;
    localparam int A_WIDTH = $clog2(A) + 1;
    localparam int ADDR_W  = $clog2(J * I * A) + 1;

    logic               start;
    logic               busy;
    logic               done;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic [DATA_W-1:0]  rd_data;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic [J_WIDTH-1:0] out_j;
    logic [I_WIDTH-1:0] out_i;
    logic [A_WIDTH-1:0] out_a;
    logic               out_last;
`ifdef CASE4_SEQ_ABORT_EN
    logic               abort;
`endif

    modport master (
`ifdef CASE4_SEQ_ABORT_EN
        input  abort,
`endif
        input  start,
        output busy, done,
        output rd_en, rd_addr,
        input  rd_data,
        output out_valid,
        input  out_ready,
        output out_data, out_j, out_i, out_a, out_last
    );

    modport slave (
`ifdef CASE4_SEQ_ABORT_EN
        output abort,
`endif
        output start,
        input  busy, done,
        input  rd_en, rd_addr,
        output rd_data,
        input  out_valid,
        output out_ready,
        input  out_data, out_j, out_i, out_a, out_last
    );
endinterface

// File: rtl/case4_operand_sequencer.sv
// Purpose: sweeps operand memory in (j, i, a) order (a fastest) and streams indexed operand beats.
// Latency: first out_valid two clock edges after the edge that samples start; then one beat per cycle.
// Backpressure: 2-entry output buffer; reads issue only while buffered + in-flight beats stay below 2.
//
// Ports: clk, rst_n (async active-low); bus (master modport) carries start/busy/done,
// the rd_en/rd_addr/rd_data read port (data one cycle after rd_en) and the out_* beat stream.
// Optional macro CASE4_SEQ_ABORT_EN adds bus.abort: flushes the sweep and pulses done without a last beat.
module case4_operand_sequencer #(
    parameter int J      = 4,
    parameter int I      = 7,
    parameter int A      = 4,
    parameter int DATA_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    case4_operand_sequencer_if.master bus
);
    localparam int J_WIDTH = $clog2(J) + 1;
    localparam int I_WIDTH = $clog2(I) + 1;
    localparam int A_WIDTH = $clog2(A) + 1;
    localparam int ADDR_W  = $clog2(J * I * A) + 1;

    localparam logic [J_WIDTH-1:0] J_LAST = J_WIDTH'(J - 1);
    localparam logic [I_WIDTH-1:0] I_LAST = I_WIDTH'(I - 1);
    localparam logic [A_WIDTH-1:0] A_LAST = A_WIDTH'(A - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [J_WIDTH-1:0] j;
        logic [I_WIDTH-1:0] i;
        logic [A_WIDTH-1:0] a;
        logic               last;
    } tag_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        tag_t              tag;
    } beat_t;

    state_t             state_q;
    logic               busy_q;
    logic               done_q;
    logic [J_WIDTH-1:0] j_q;
    logic [I_WIDTH-1:0] i_q;
    logic [A_WIDTH-1:0] a_q;
    logic [ADDR_W-1:0]  addr_q;

    // Read issued last cycle: its data is on rd_data now, its indices wait here.
    logic               inflight_q;
    tag_t               inflight_tag_q;

    beat_t              buf_q [2];
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [1:0]         cnt_q;

    beat_t              head;
    logic               out_vld;
    logic               pop;
    logic               last_rd;
    logic               rd_go;
    logic               abort_req;
    logic [2:0]         credit;

    assign head    = buf_q[rd_ptr_q];
    assign out_vld = (cnt_q != 2'd0);
    assign pop     = out_vld & bus.out_ready;
    assign last_rd = (j_q == J_LAST) && (i_q == I_LAST) && (a_q == A_LAST);

`ifdef CASE4_SEQ_ABORT_EN
    assign abort_req = bus.abort && (state_q != IDLE);
`else
    assign abort_req = 1'b0;
`endif

    // Slots committed after this cycle, counting a slot freed by this cycle's pop, so a
    // read can issue every cycle while the consumer keeps up.
    assign credit = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_go  = (state_q == RUN) && !abort_req && (credit < 3'd2);

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rd_en     = rd_go;
    assign bus.rd_addr   = addr_q;
    assign bus.out_valid = out_vld;
    assign bus.out_data  = head.data;
    assign bus.out_j     = head.tag.j;
    assign bus.out_i     = head.tag.i;
    assign bus.out_a     = head.tag.a;
    assign bus.out_last  = head.tag.last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            j_q            <= '0;
            i_q            <= '0;
            a_q            <= '0;
            addr_q         <= '0;
            inflight_q     <= 1'b0;
            inflight_tag_q <= '0;
            buf_q[0]       <= '0;
            buf_q[1]       <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            cnt_q          <= 2'd0;
        end else begin
            done_q <= 1'b0;

            // Output buffer and in-flight read tracking.
            if (abort_req) begin
                inflight_q <= 1'b0;
                wr_ptr_q   <= 1'b0;
                rd_ptr_q   <= 1'b0;
                cnt_q      <= 2'd0;
            end else begin
                if (inflight_q) begin
                    buf_q[wr_ptr_q] <= '{data: bus.rd_data, tag: inflight_tag_q};
                    wr_ptr_q        <= ~wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
                cnt_q      <= cnt_q + {1'b0, inflight_q} - {1'b0, pop};
                inflight_q <= rd_go;
                if (rd_go) begin
                    inflight_tag_q <= '{j: j_q, i: i_q, a: a_q, last: last_rd};
                end
            end

            // Read address walk; wraps to zero after the final read.
            if (rd_go) begin
                if (last_rd) begin
                    j_q    <= '0;
                    i_q    <= '0;
                    a_q    <= '0;
                    addr_q <= '0;
                end else begin
                    addr_q <= addr_q + ADDR_W'(1);
                    if (a_q == A_LAST) begin
                        a_q <= '0;
                        if (i_q == I_LAST) begin
                            i_q <= '0;
                            j_q <= j_q + J_WIDTH'(1);
                        end else begin
                            i_q <= i_q + I_WIDTH'(1);
                        end
                    end else begin
                        a_q <= a_q + A_WIDTH'(1);
                    end
                end
            end

            case (state_q)
                IDLE: begin
                    // A start landing on the done cycle belongs to the finished sweep.
                    if (bus.start && !done_q) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        j_q     <= '0;
                        i_q     <= '0;
                        a_q     <= '0;
                        addr_q  <= '0;
                    end
                end
                RUN: begin
                    if (abort_req) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (rd_go && last_rd) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (abort_req || (pop && head.tag.last)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule
